// File: rtl/test_completion_monitor_if.sv
// Snoop/status bundle between a core-side bench and the end-of-test monitor.
// master drives the snooped core signals; slave is the monitor.
interface test_completion_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic                  start;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  retire_valid;

    logic                  done;
    logic                  pass;
    logic                  fail;
    logic                  timeout;
    logic                  hang;
    logic [DATA_W-2:0]     fail_code;
    logic [CNT_W-1:0]      cycle_count;
    logic [CNT_W-1:0]      retire_count;
    logic [7:0]            ignored_count;

    modport master (
        output start, wr_en, wr_addr, wr_data, wr_be, retire_valid,
        input  done, pass, fail, timeout, hang, fail_code,
               cycle_count, retire_count, ignored_count
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_data, wr_be, retire_valid,
        output done, pass, fail, timeout, hang, fail_code,
               cycle_count, retire_count, ignored_count
    );
endinterface

// File: rtl/test_completion_monitor.sv
// Passive end-of-test monitor: decodes TOHOST pass/fail stores, counts cycles/retirements, flags timeout and hang.
// Latency: one edge from sampled input to registered flags/counters; purely observational, never stalls the core.
module test_completion_monitor #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                HANG_CYCLES    = 256,
    parameter int                CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    test_completion_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int               HANG_W      = $clog2(HANG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [HANG_W-1:0] HANG_LIM   = HANG_W'(HANG_CYCLES);

    state_t              state_q;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    retire_q, retire_d;
    logic [HANG_W-1:0]   quiet_q, quiet_d;
    logic [7:0]          ignored_q, ignored_d;
    logic                done_q, pass_q, fail_q, timeout_q, hang_q;
    logic [DATA_W-2:0]   fail_code_q;

    logic tohost_hit, be_full, pass_hit, fail_hit, ignore_hit, timeout_hit, hang_hit;

    always_comb begin
        tohost_hit  = mon.wr_en && (mon.wr_addr == TOHOST_ADDR);
        be_full     = &mon.wr_be;
        pass_hit    = tohost_hit && be_full && (mon.wr_data == DATA_W'(1));
        fail_hit    = tohost_hit && be_full && mon.wr_data[0] && !pass_hit;
        ignore_hit  = tohost_hit && !pass_hit && !fail_hit;

        cycle_d     = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
        // A count parked at saturation must not re-trigger the compare.
        timeout_hit = (cycle_q != CNT_MAX) && (cycle_d == TIMEOUT_LIM);

        retire_d    = retire_q;
        if (mon.retire_valid && (retire_q != CNT_MAX)) begin
            retire_d = retire_q + CNT_W'(1);
        end

        quiet_d     = mon.retire_valid ? '0 : quiet_q + HANG_W'(1);
        hang_hit    = !mon.retire_valid && (quiet_d == HANG_LIM);

        ignored_d   = (ignore_hit && (ignored_q != 8'hFF)) ? ignored_q + 8'd1 : ignored_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cycle_q     <= '0;
            retire_q    <= '0;
            quiet_q     <= '0;
            ignored_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hang_q      <= 1'b0;
            fail_code_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mon.start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cycle_q   <= cycle_d;
                    retire_q  <= retire_d;
                    quiet_q   <= quiet_d;
                    ignored_q <= ignored_d;
                    // Only one terminal cause is ever recorded: pass/fail > timeout > hang.
                    if (pass_hit) begin
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (fail_hit) begin
                        fail_q      <= 1'b1;
                        fail_code_q <= mon.wr_data[DATA_W-1:1];
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (hang_hit) begin
                        hang_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mon.done          = done_q;
    assign mon.pass          = pass_q;
    assign mon.fail          = fail_q;
    assign mon.timeout       = timeout_q;
    assign mon.hang          = hang_q;
    assign mon.fail_code     = fail_code_q;
    assign mon.cycle_count   = cycle_q;
    assign mon.retire_count  = retire_q;
    assign mon.ignored_count = ignored_q;
endmodule

// File: tb/tb_test_completion_monitor.sv
// Bench for test_completion_monitor: directed scenarios against spec constants, then random episodes against a reference model.
module tb_test_completion_monitor;
    localparam int          TOUT   = 50;
    localparam int          HANG   = 8;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam longint      CMAX   = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    test_completion_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) ifc ();

    test_completion_monitor #(
        .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST),
        .TIMEOUT_CYCLES(TOUT), .HANG_CYCLES(HANG), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(ifc.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model kept in the terms of the behaviour description.
    bit          m_armed, m_ended;
    longint      m_cyc, m_ret, m_quiet;
    int          m_ign;
    bit          m_pass, m_fail, m_tout, m_hang;
    logic [30:0] m_code;

    task automatic step(input bit r, input bit st, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit ret);
        rst = r;
        ifc.start = st; ifc.wr_en = we; ifc.wr_addr = a;
        ifc.wr_data = d; ifc.wr_be = be; ifc.retire_valid = ret;
        @(posedge clk);
        if (r) begin
            m_armed = 0; m_ended = 0; m_cyc = 0; m_ret = 0; m_quiet = 0; m_ign = 0;
            m_pass = 0; m_fail = 0; m_tout = 0; m_hang = 0; m_code = '0;
        end else if (!m_armed && !m_ended) begin
            if (st) m_armed = 1;
        end else if (m_armed) begin
            if (m_cyc < CMAX) m_cyc++;
            if (ret) begin
                if (m_ret < CMAX) m_ret++;
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
            if (we && a == TOHOST) begin
                if (be == 4'hF && d == 32'd1) m_pass = 1;
                else if (be == 4'hF && d[0]) begin m_fail = 1; m_code = d[31:1]; end
                else if (m_ign < 255) m_ign++;
            end
            if (!m_pass && !m_fail) begin
                if (m_cyc == TOUT) m_tout = 1;
                else if (m_quiet == HANG) m_hang = 1;
            end
            if (m_pass || m_fail || m_tout || m_hang) begin
                m_armed = 0; m_ended = 1;
            end
        end
        #1;
    endtask

    task automatic idle_step(input bit ret);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, ret);
    endtask

    task automatic wr_step(input logic [31:0] d, input logic [3:0] be, input bit ret);
        step(0, 0, 1, TOHOST, d, be, ret);
    endtask

    task automatic arm();
        step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step(0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step(1, 1, 1, TOHOST, 32'h1, 4'hF, 1);
        n_cmp++;
        if ({ifc.done, ifc.pass, ifc.fail, ifc.timeout, ifc.hang} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                              {ifc.done, ifc.pass, ifc.fail, ifc.timeout, ifc.hang});
        end
        n_cmp++;
        if (ifc.cycle_count !== 0 || ifc.retire_count !== 0 || ifc.ignored_count !== 0 || ifc.fail_code !== 0) begin
            n_bad++; $display("FAIL reset_counts: got cyc=%0d ret=%0d ign=%0d code=%0d want all 0",
                              ifc.cycle_count, ifc.retire_count, ifc.ignored_count, ifc.fail_code);
        end
    endtask

    task automatic test_pass();
        arm();
        for (int i = 0; i < 5; i++) idle_step(1);
        wr_step(32'h1, 4'hF, 0);
        n_cmp++;
        if ({ifc.pass, ifc.done, ifc.fail} !== 3'b110) begin
            n_bad++; $display("FAIL pass_flags: got pass,done,fail=%b want 110", {ifc.pass, ifc.done, ifc.fail});
        end
        n_cmp++;
        if (ifc.cycle_count !== 6 || ifc.retire_count !== 5) begin
            n_bad++; $display("FAIL pass_counts: got cyc=%0d ret=%0d want 6 5", ifc.cycle_count, ifc.retire_count);
        end
        wr_step(32'h7, 4'hF, 1);
        step(0, 1, 0, 32'h0, 32'h0, 4'h0, 1);
        n_cmp++;
        if (ifc.cycle_count !== 6 || ifc.retire_count !== 5 || ifc.fail !== 1'b0 || ifc.pass !== 1'b1) begin
            n_bad++; $display("FAIL pass_frozen: got cyc=%0d ret=%0d fail=%b pass=%b want 6 5 0 1",
                              ifc.cycle_count, ifc.retire_count, ifc.fail, ifc.pass);
        end
    endtask

    task automatic test_fail();
        arm();
        idle_step(1); idle_step(1);
        wr_step(32'h0000_0007, 4'hF, 1);
        n_cmp++;
        if ({ifc.fail, ifc.done, ifc.pass} !== 3'b110 || ifc.fail_code !== 31'd3) begin
            n_bad++; $display("FAIL fail_decode: got fail,done,pass=%b code=%0d want 110 3",
                              {ifc.fail, ifc.done, ifc.pass}, ifc.fail_code);
        end
        wr_step(32'h1, 4'hF, 1);
        n_cmp++;
        if (ifc.pass !== 1'b0 || ifc.fail !== 1'b1 || ifc.fail_code !== 31'd3) begin
            n_bad++; $display("FAIL fail_sticky: got pass=%b fail=%b code=%0d want 0 1 3", ifc.pass, ifc.fail, ifc.fail_code);
        end
    endtask

    task automatic test_timeout();
        arm();
        for (int i = 0; i < TOUT - 1; i++) idle_step(1);
        n_cmp++;
        if (ifc.timeout !== 1'b0 || ifc.done !== 1'b0 || ifc.cycle_count !== TOUT - 1) begin
            n_bad++; $display("FAIL timeout_early: got timeout=%b done=%b cyc=%0d want 0 0 %0d",
                              ifc.timeout, ifc.done, ifc.cycle_count, TOUT - 1);
        end
        idle_step(1);
        n_cmp++;
        if ({ifc.timeout, ifc.done, ifc.hang} !== 3'b110 || ifc.cycle_count !== TOUT) begin
            n_bad++; $display("FAIL timeout_fire: got timeout,done,hang=%b cyc=%0d want 110 %0d",
                              {ifc.timeout, ifc.done, ifc.hang}, ifc.cycle_count, TOUT);
        end
        for (int i = 0; i < 3; i++) idle_step(1);
        n_cmp++;
        if (ifc.cycle_count !== TOUT || ifc.retire_count !== TOUT || ifc.timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_frozen: got cyc=%0d ret=%0d timeout=%b want %0d %0d 1",
                              ifc.cycle_count, ifc.retire_count, ifc.timeout, TOUT, TOUT);
        end
    endtask

    task automatic test_hang();
        arm();
        for (int i = 0; i < HANG - 1; i++) idle_step(0);
        n_cmp++;
        if (ifc.hang !== 1'b0) begin
            n_bad++; $display("FAIL hang_early: got hang=%b want 0", ifc.hang);
        end
        idle_step(0);
        n_cmp++;
        if ({ifc.hang, ifc.done} !== 2'b11 || ifc.cycle_count !== HANG) begin
            n_bad++; $display("FAIL hang_fire: got hang,done=%b cyc=%0d want 11 %0d", {ifc.hang, ifc.done}, ifc.cycle_count, HANG);
        end
        arm();
        for (int i = 0; i < 6; i++) idle_step(0);
        idle_step(1);
        for (int i = 0; i < 7; i++) idle_step(0);
        n_cmp++;
        if (ifc.hang !== 1'b0 || ifc.cycle_count !== 14) begin
            n_bad++; $display("FAIL hang_restart_early: got hang=%b cyc=%0d want 0 14", ifc.hang, ifc.cycle_count);
        end
        idle_step(0);
        n_cmp++;
        if (ifc.hang !== 1'b1 || ifc.cycle_count !== 15 || ifc.retire_count !== 1) begin
            n_bad++; $display("FAIL hang_restart: got hang=%b cyc=%0d ret=%0d want 1 15 1",
                              ifc.hang, ifc.cycle_count, ifc.retire_count);
        end
    endtask

    task automatic test_ignored();
        arm();
        wr_step(32'h2, 4'h3, 1);
        wr_step(32'h0, 4'h3, 1);
        wr_step(32'h1, 4'h3, 1);
        step(0, 0, 1, TOHOST + 32'h4, 32'h1, 4'hF, 1);
        step(0, 0, 1, TOHOST, 32'h1, 4'hF, 1);
        n_cmp++;
        if (ifc.pass !== 1'b1 || ifc.ignored_count !== 8'd3) begin
            n_bad++; $display("FAIL ignored_then_pass: got pass=%b ign=%0d want 1 3", ifc.pass, ifc.ignored_count);
        end
        arm();
        wr_step(32'h2, 4'hF, 1);
        wr_step(32'h0, 4'hF, 1);
        wr_step(32'h1, 4'h3, 1);
        n_cmp++;
        if (ifc.ignored_count !== 8'd3 || ifc.done !== 1'b0) begin
            n_bad++; $display("FAIL ignored_count: got ign=%0d done=%b want 3 0", ifc.ignored_count, ifc.done);
        end
        for (int i = 3; i < TOUT - 1; i++) idle_step(1);
        wr_step(32'h1, 4'hF, 1);
        n_cmp++;
        if ({ifc.pass, ifc.timeout, ifc.done} !== 3'b101 || ifc.cycle_count !== TOUT) begin
            n_bad++; $display("FAIL pass_over_timeout: got pass,timeout,done=%b cyc=%0d want 101 %0d",
                              {ifc.pass, ifc.timeout, ifc.done}, ifc.cycle_count, TOUT);
        end
    endtask

    task automatic test_reset_mid_run();
        arm();
        for (int i = 0; i < 20; i++) idle_step(1);
        n_cmp++;
        if (ifc.cycle_count !== 20) begin
            n_bad++; $display("FAIL mid_pre: got cyc=%0d want 20", ifc.cycle_count);
        end
        step(1, 1, 0, 32'h0, 32'h0, 4'h0, 1);
        n_cmp++;
        if (ifc.cycle_count !== 0 || ifc.retire_count !== 0 || ifc.done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got cyc=%0d ret=%0d done=%b want 0 0 0",
                              ifc.cycle_count, ifc.retire_count, ifc.done);
        end
        idle_step(1); idle_step(1);
        n_cmp++;
        if (ifc.cycle_count !== 0 || ifc.retire_count !== 0) begin
            n_bad++; $display("FAIL mid_idle: got cyc=%0d ret=%0d want 0 0 (start with rst must not arm)",
                              ifc.cycle_count, ifc.retire_count);
        end
        step(0, 1, 0, 32'h0, 32'h0, 4'h0, 1);
        idle_step(1);
        n_cmp++;
        if (ifc.cycle_count !== 1 || ifc.retire_count !== 1) begin
            n_bad++; $display("FAIL mid_rearm: got cyc=%0d ret=%0d want 1 1", ifc.cycle_count, ifc.retire_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] dpool [8] = '{32'h1, 32'h3, 32'h0, 32'h2, 32'h8, 32'hFFFF_FFFF, 32'h1, 32'h0000_0051};
        for (int ep = 0; ep < 40; ep++) begin
            int stall_pct;
            stall_pct = (ep % 3 == 0) ? 60 : 5;
            arm();
            for (int c = 0; c < TOUT + 6; c++) begin
                bit          r, st, we, ret;
                logic [31:0] a, d;
                logic [3:0]  be;
                r   = ($urandom_range(0, 299) == 0);
                st  = ($urandom_range(0, 9) == 0);
                we  = ($urandom_range(0, 99) < 6);
                a   = ($urandom_range(0, 3) == 0) ? (TOHOST ^ (32'h1 << $urandom_range(0, 31))) : TOHOST;
                d   = ($urandom_range(0, 3) == 0) ? $urandom : dpool[$urandom_range(0, 7)];
                be  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                ret = ($urandom_range(0, 99) >= stall_pct);
                step(r, st, we, a, d, be, ret);
                n_cmp++;
                if ({ifc.done, ifc.pass, ifc.fail, ifc.timeout, ifc.hang} !==
                    {m_ended, m_pass, m_fail, m_tout, m_hang}) begin
                    n_bad++; $display("FAIL rnd_flags ep%0d c%0d: got %b want %b", ep, c,
                                      {ifc.done, ifc.pass, ifc.fail, ifc.timeout, ifc.hang},
                                      {m_ended, m_pass, m_fail, m_tout, m_hang});
                end
                n_cmp++;
                if (ifc.cycle_count !== 32'(m_cyc) || ifc.retire_count !== 32'(m_ret) ||
                    ifc.ignored_count !== 8'(m_ign) || ifc.fail_code !== m_code) begin
                    n_bad++; $display("FAIL rnd_counts ep%0d c%0d: got cyc=%0d ret=%0d ign=%0d code=%0h want %0d %0d %0d %0h",
                                      ep, c, ifc.cycle_count, ifc.retire_count, ifc.ignored_count, ifc.fail_code,
                                      m_cyc, m_ret, m_ign, m_code);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.start = 0; ifc.wr_en = 0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.wr_be = '0; ifc.retire_valid = 0;
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_hang();
        test_ignored();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
